// File: rtl/wb_ecall_unit.sv
// Writeback stage: result mux, register-file write port, ECALL host handshake and exit halt.
// Optional build macro WB_ECALL_TIMEOUT_EN adds a host response timeout that writes a0 = -1.
module wb_ecall_unit #(
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned REG_W       = 5,
   parameter int unsigned RSLT_W      = 3,
   parameter int unsigned EXIT_CODE   = 93,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [RSLT_W-1:0] resultSrc_in,
   input  logic              regWrite_in,
   input  logic              ecall_in,
   input  logic [DATA_W-1:0] ALUResult_in,
   input  logic [DATA_W-1:0] readData_in,
   input  logic [DATA_W-1:0] PCPlusImm_in,
   input  logic [REG_W-1:0]  writeReg_in,
   input  logic [DATA_W-1:0] immExt_in,
   input  logic [DATA_W-1:0] PCPlus4_in,
   input  logic [DATA_W-1:0] a7_val,
   input  logic [DATA_W-1:0] a0_val,
   output logic              rf_we,
   output logic [REG_W-1:0]  rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              stall,
   output logic              halted,
   output logic              host_req_valid,
   input  logic              host_req_ready,
   output logic [DATA_W-1:0] host_req_code,
   output logic [DATA_W-1:0] host_req_arg,
   input  logic              host_rsp_valid,
   input  logic [DATA_W-1:0] host_rsp_data,
   output logic [31:0]       ecall_count
);

   localparam int unsigned CNT_W  = 32;
   localparam int unsigned A0_REG = 10;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_RSP  = 3'd2,
      S_DONE = 3'd3,
      S_HALT = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [DATA_W-1:0]  code_q, code_d;
   logic [DATA_W-1:0]  arg_q, arg_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [DATA_W-1:0]  wb_mux;

`ifdef WB_ECALL_TIMEOUT_EN
   logic [CNT_W-1:0]   tmo_q, tmo_d;
`else
   logic               unused_tmo;
   assign unused_tmo = ^CNT_W'(TIMEOUT_CYC);
`endif

   // Writeback result select
   always_comb begin
      case (resultSrc_in)
         RSLT_W'(0): wb_mux = ALUResult_in;
         RSLT_W'(1): wb_mux = readData_in;
         RSLT_W'(2): wb_mux = PCPlus4_in;
         RSLT_W'(3): wb_mux = immExt_in;
         RSLT_W'(4): wb_mux = PCPlusImm_in;
         default:    wb_mux = '0;
      endcase
   end

   // Next-state and combinational writeback/stall outputs
   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      arg_d    = arg_q;
      count_d  = count_q;
      rf_we    = 1'b0;
      rf_waddr = writeReg_in;
      rf_wdata = wb_mux;
      stall    = 1'b0;
`ifdef WB_ECALL_TIMEOUT_EN
      tmo_d    = tmo_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (ecall_in) begin
               stall   = 1'b1;
               code_d  = a7_val;
               arg_d   = a0_val;
               state_d = (a7_val == DATA_W'(EXIT_CODE)) ? S_HALT : S_REQ;
            end else begin
               rf_we = regWrite_in && (writeReg_in != '0);
            end
         end
         S_REQ: begin
            stall = 1'b1;
            if (host_req_ready) begin
               state_d = S_RSP;
`ifdef WB_ECALL_TIMEOUT_EN
               tmo_d   = '0;
`endif
            end
         end
         S_RSP: begin
            stall = 1'b1;
            if (host_rsp_valid) begin
               rf_we    = 1'b1;
               rf_waddr = REG_W'(A0_REG);
               rf_wdata = host_rsp_data;
               state_d  = S_DONE;
            end
`ifdef WB_ECALL_TIMEOUT_EN
            else if (tmo_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               rf_we    = 1'b1;
               rf_waddr = REG_W'(A0_REG);
               rf_wdata = '1;
               state_d  = S_DONE;
            end else begin
               tmo_d = tmo_q + CNT_W'(1);
            end
`endif
         end
         S_DONE: begin
            count_d = count_q + CNT_W'(1);
            state_d = S_IDLE;
         end
         S_HALT: begin
            stall = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      // Reset forces the write port and stall quiet even while inputs are live
      if (!reset) begin
         rf_we = 1'b0;
         stall = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         code_q  <= '0;
         arg_q   <= '0;
         count_q <= '0;
`ifdef WB_ECALL_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         arg_q   <= arg_d;
         count_q <= count_d;
`ifdef WB_ECALL_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign host_req_valid = (state_q == S_REQ);
   assign halted         = (state_q == S_HALT);
   assign host_req_code  = code_q;
   assign host_req_arg   = arg_q;
   assign ecall_count    = count_q;

endmodule

// File: tb/tb_wb_ecall_unit.sv
// Directed bench for wb_ecall_unit: writeback mux, ECALL handshake, reset abort, exit halt.
// With WB_ECALL_TIMEOUT_EN defined it also covers the response timeout (TIMEOUT_CYC=8).
module tb_wb_ecall_unit;

   logic        clk;
   logic        rst_n;
   logic [2:0]  resultSrc;
   logic        regWrite;
   logic        ecall;
   logic [63:0] alu_res, rd_data, pc_imm, imm_ext, pc4, a7, a0;
   logic [4:0]  wreg;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic        stall, halted, req_valid, req_ready, rsp_valid;
   logic [63:0] req_code, req_arg, rsp_data;
   logic [31:0] ecall_count;

   int n_checks = 0;
   int n_fail   = 0;

   wb_ecall_unit #(
      .DATA_W(64), .REG_W(5), .RSLT_W(3), .EXIT_CODE(93), .TIMEOUT_CYC(8)
   ) dut (
      .clk(clk), .reset(rst_n),
      .resultSrc_in(resultSrc), .regWrite_in(regWrite), .ecall_in(ecall),
      .ALUResult_in(alu_res), .readData_in(rd_data), .PCPlusImm_in(pc_imm),
      .writeReg_in(wreg), .immExt_in(imm_ext), .PCPlus4_in(pc4),
      .a7_val(a7), .a0_val(a0),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .stall(stall), .halted(halted),
      .host_req_valid(req_valid), .host_req_ready(req_ready),
      .host_req_code(req_code), .host_req_arg(req_arg),
      .host_rsp_valid(rsp_valid), .host_rsp_data(rsp_data),
      .ecall_count(ecall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are checked 1ns later
   task automatic next_cyc();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   // Launch a non-exit ECALL from IDLE and accept it immediately; leaves the DUT entering RSP
   task automatic ecall_to_rsp(input logic [63:0] code);
      next_cyc();
      ecall = 1'b1; a7 = code; a0 = 64'h55;
      next_cyc();
      req_ready = 1'b1;
      next_cyc();
      req_ready = 1'b0;
   endtask

   logic [63:0] mux_exp [8];

   initial begin
      rst_n = 1'b0; resultSrc = '0; regWrite = 1'b1; ecall = 1'b0; wreg = 5'd7;
      alu_res = 64'hA1; rd_data = 64'hB2; pc4 = 64'h104; imm_ext = 64'hC3; pc_imm = 64'hD4;
      a7 = '0; a0 = '0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
      mux_exp = '{64'hA1, 64'hB2, 64'h104, 64'hC3, 64'hD4, 64'h0, 64'h0, 64'h0};

      // Reset values, with regWrite active on the inputs
      next_cyc(); settle();
      check_eq("rst_rf_we", 64'(rf_we), 64'd0);
      check_eq("rst_stall", 64'(stall), 64'd0);
      check_eq("rst_halted", 64'(halted), 64'd0);
      check_eq("rst_req_valid", 64'(req_valid), 64'd0);
      check_eq("rst_code", req_code, 64'd0);
      check_eq("rst_arg", req_arg, 64'd0);
      check_eq("rst_count", 64'(ecall_count), 64'd0);

      // Normal writeback across every result select
      next_cyc(); rst_n = 1'b1;
      resultSrc = 3'd2; wreg = 5'd5; settle();
      check_eq("wb_we", 64'(rf_we), 64'd1);
      check_eq("wb_addr", 64'(rf_waddr), 64'd5);
      check_eq("wb_data", rf_wdata, 64'h104);
      for (int s = 0; s < 8; s++) begin
         next_cyc(); resultSrc = 3'(s); settle();
         check_eq($sformatf("mux_src%0d", s), rf_wdata, mux_exp[s]);
      end
      next_cyc(); wreg = 5'd0; settle();
      check_eq("wb_x0_we", 64'(rf_we), 64'd0);
      next_cyc(); wreg = 5'd4; regWrite = 1'b0; settle();
      check_eq("wb_nowrite_we", 64'(rf_we), 64'd0);

      // ECALL a7=64, a0=0x1234, ready on the third REQ cycle, response 7
      next_cyc();
      regWrite = 1'b1; wreg = 5'd3; ecall = 1'b1; a7 = 64'd64; a0 = 64'h1234; settle();
      check_eq("ec_idle_stall", 64'(stall), 64'd1);
      check_eq("ec_idle_we", 64'(rf_we), 64'd0);
      check_eq("ec_idle_valid", 64'(req_valid), 64'd0);
      for (int i = 0; i < 3; i++) begin
         next_cyc();
         a7 = 64'hDEAD; a0 = 64'hBEEF;
         req_ready = (i == 2); rsp_valid = 1'b1; rsp_data = 64'hBAD; settle();
         check_eq($sformatf("req%0d_valid", i), 64'(req_valid), 64'd1);
         check_eq($sformatf("req%0d_code", i), req_code, 64'd64);
         check_eq($sformatf("req%0d_arg", i), req_arg, 64'h1234);
         check_eq($sformatf("req%0d_stall", i), 64'(stall), 64'd1);
         check_eq($sformatf("req%0d_we", i), 64'(rf_we), 64'd0);
      end
      next_cyc(); req_ready = 1'b0; rsp_valid = 1'b0; settle();
      check_eq("rsp_wait_valid", 64'(req_valid), 64'd0);
      check_eq("rsp_wait_stall", 64'(stall), 64'd1);
      check_eq("rsp_wait_we", 64'(rf_we), 64'd0);
      next_cyc(); rsp_valid = 1'b1; rsp_data = 64'd7; settle();
      check_eq("rsp_we", 64'(rf_we), 64'd1);
      check_eq("rsp_addr", 64'(rf_waddr), 64'd10);
      check_eq("rsp_data", rf_wdata, 64'd7);
      check_eq("rsp_stall", 64'(stall), 64'd1);
      next_cyc(); rsp_valid = 1'b0; settle();
      check_eq("done_stall", 64'(stall), 64'd0);
      check_eq("done_we", 64'(rf_we), 64'd0);
      check_eq("done_count", 64'(ecall_count), 64'd0);
      next_cyc(); ecall = 1'b0; settle();
      check_eq("post_count", 64'(ecall_count), 64'd1);
      check_eq("post_valid", 64'(req_valid), 64'd0);
      check_eq("post_we", 64'(rf_we), 64'd1);
      check_eq("post_stall", 64'(stall), 64'd0);
      for (int i = 0; i < 3; i++) begin
         next_cyc(); settle();
         check_eq($sformatf("no_rereq%0d", i), 64'(req_valid), 64'd0);
      end

      // Asynchronous reset in RSP
      ecall_to_rsp(64'd1);
      settle();
      check_eq("abort_pre_stall", 64'(stall), 64'd1);
      ecall = 1'b0; #1; rst_n = 1'b0; #1;
      check_eq("abort_stall", 64'(stall), 64'd0);
      check_eq("abort_valid", 64'(req_valid), 64'd0);
      check_eq("abort_we", 64'(rf_we), 64'd0);
      check_eq("abort_code", req_code, 64'd0);
      check_eq("abort_count", 64'(ecall_count), 64'd0);
      next_cyc(); rst_n = 1'b1; resultSrc = 3'd0; wreg = 5'd9; settle();
      check_eq("resume_we", 64'(rf_we), 64'd1);
      check_eq("resume_addr", 64'(rf_waddr), 64'd9);
      check_eq("resume_data", rf_wdata, 64'hA1);

`ifdef WB_ECALL_TIMEOUT_EN
      // No host response: a0 = -1 written on the eighth RSP cycle
      ecall_to_rsp(64'd2);
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) next_cyc();
         settle();
         check_eq($sformatf("tmo%0d_we", k), 64'(rf_we), (k == 8) ? 64'd1 : 64'd0);
      end
      check_eq("tmo_addr", 64'(rf_waddr), 64'd10);
      check_eq("tmo_data", rf_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
      next_cyc(); ecall = 1'b0; settle();
      check_eq("tmo_done_stall", 64'(stall), 64'd0);
`endif

      // Exit syscall halts permanently, host traffic ignored
      next_cyc(); ecall = 1'b1; a7 = 64'd93; settle();
      check_eq("exit_stall", 64'(stall), 64'd1);
      check_eq("exit_halted_early", 64'(halted), 64'd0);
      next_cyc(); req_ready = 1'b1; rsp_valid = 1'b1; ecall = 1'b0; regWrite = 1'b1;
      for (int i = 0; i < 100; i++) begin
         settle();
         check_eq("halt_halted", 64'(halted), 64'd1);
         check_eq("halt_stall", 64'(stall), 64'd1);
         check_eq("halt_valid", 64'(req_valid), 64'd0);
         check_eq("halt_we", 64'(rf_we), 64'd0);
         next_cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
